// File: rtl/aurora_latency_sequencer.sv
// ---------------------------------------------------------------------------
// aurora_latency_sequencer
//
// Drives one clock-cycle timer to measure Aurora link round-trip latency.
// A run is N_MEAS trials. Each trial does the following:
//   1. clear the timer
//   2. request a test-pattern send
//   3. start the timer on acknowledge
//   4. stop the timer on pattern match or on timeout
//   5. let the timer settle, then sample it
// Matched trials feed min/max/sum statistics for the readout register block.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for cmd_start_i
// CLEAR    | one-cycle timer_rst_o pulse
// SEND     | send_req_o held until send_ack_i
// WAIT_RX  | timer running, waiting for rx_match_i or timeout
// SETTLE   | two cycles (first carries timer_stop_o) for timer to freeze
// SAMPLE   | fold timer_count_i into statistics, advance trial counter
// DONE     | statistics valid, done_o held until next cmd_start_i
//
// Ports
//   clk_i, reset_i            clock, async active-high reset
//   cmd_start_i, cmd_abort_i  one-cycle run / abort requests
//   send_req_o, send_ack_i    pattern generator handshake
//   rx_match_i                pattern checker match pulse
//   timer_rst_o/start_o/stop_o, timer_count_i   timer control and value
//   busy_o, done_o            run status
//   min_lat_o, max_lat_o, sum_lat_o, n_ok_o, n_timeout_o   statistics
// All outputs are registered.
// ---------------------------------------------------------------------------
module aurora_latency_sequencer #(
    parameter int N_MEAS  = 16,
    parameter int TIMEOUT = 65535,
    parameter int WIDTH   = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_start_i,
    input  logic             cmd_abort_i,
    output logic             send_req_o,
    input  logic             send_ack_i,
    input  logic             rx_match_i,
    output logic             timer_rst_o,
    output logic             timer_start_o,
    output logic             timer_stop_o,
    input  logic [WIDTH-1:0] timer_count_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] min_lat_o,
    output logic [WIDTH-1:0] max_lat_o,
    output logic [WIDTH+7:0] sum_lat_o,
    output logic [7:0]       n_ok_o,
    output logic [7:0]       n_timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SEND, S_WAIT_RX, S_SETTLE, S_SAMPLE, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [23:0]        tmo_q, tmo_d;
    logic               settle_q, settle_d;
    logic               ok_q, ok_d;
    logic [7:0]         trial_q, trial_d;
    logic [WIDTH-1:0]   min_q, min_d, max_q, max_d;
    logic [WIDTH+7:0]   sum_q, sum_d;
    logic [7:0]         n_ok_q, n_ok_d, n_to_q, n_to_d;
    logic               send_req_q, send_req_d, busy_q, busy_d, done_q, done_d;
    logic               t_rst_q, t_rst_d, t_start_q, t_start_d, t_stop_q, t_stop_d;

    logic idle_like, abort_ok, start_ok, rx_end;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign abort_ok  = cmd_abort_i && !idle_like;
    assign start_ok  = cmd_start_i && idle_like;
    // A match on the timeout cycle wins: rx_match_i decides ok vs. lost.
    assign rx_end    = (state_q == S_WAIT_RX) && (rx_match_i || tmo_q == 24'd0);

    // State and datapath registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            settle_q   <= 1'b0;
            ok_q       <= 1'b0;
            trial_q    <= '0;
            min_q      <= '1;
            max_q      <= '0;
            sum_q      <= '0;
            n_ok_q     <= '0;
            n_to_q     <= '0;
            send_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            t_rst_q    <= 1'b0;
            t_start_q  <= 1'b0;
            t_stop_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            settle_q   <= settle_d;
            ok_q       <= ok_d;
            trial_q    <= trial_d;
            min_q      <= min_d;
            max_q      <= max_d;
            sum_q      <= sum_d;
            n_ok_q     <= n_ok_d;
            n_to_q     <= n_to_d;
            send_req_q <= send_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            t_rst_q    <= t_rst_d;
            t_start_q  <= t_start_d;
            t_stop_q   <= t_stop_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (cmd_start_i) state_d = S_CLEAR;
            S_CLEAR:        state_d = S_SEND;
            S_SEND:         if (send_ack_i) state_d = S_WAIT_RX;
            S_WAIT_RX:      if (rx_end) state_d = S_SETTLE;
            S_SETTLE:       if (settle_q) state_d = S_SAMPLE;
            S_SAMPLE:       state_d = (trial_q + 8'd1 == 8'(N_MEAS)) ? S_DONE : S_CLEAR;
            default:        state_d = S_IDLE;
        endcase
        if (abort_ok) state_d = S_IDLE;
    end

    // Outputs and datapath next values, all registered
    always_comb begin
        tmo_d    = tmo_q;
        ok_d     = ok_q;
        trial_d  = trial_q;
        min_d    = min_q;
        max_d    = max_q;
        sum_d    = sum_q;
        n_ok_d   = n_ok_q;
        n_to_d   = n_to_q;
        // settle_q marks the second SETTLE cycle
        settle_d = (state_q == S_SETTLE);

        send_req_d = (state_d == S_SEND);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        t_rst_d    = (state_d == S_CLEAR) || abort_ok;
        t_start_d  = (state_q == S_SEND) && (state_d == S_WAIT_RX);
        t_stop_d   = (rx_end && !abort_ok) || abort_ok;

        if (start_ok) begin
            min_d   = '1;
            max_d   = '0;
            sum_d   = '0;
            n_ok_d  = '0;
            n_to_d  = '0;
            trial_d = '0;
        end

        // Down-counter reloaded while sending; reaches zero TIMEOUT cycles
        // after the first WAIT_RX cycle.
        if (state_q == S_SEND)
            tmo_d = 24'(TIMEOUT);
        else if (state_q == S_WAIT_RX && tmo_q != 24'd0)
            tmo_d = tmo_q - 24'd1;

        if (!abort_ok) begin
            if (rx_end) begin
                ok_d = rx_match_i;
                if (!rx_match_i) n_to_d = n_to_q + 8'd1;
            end
            if (state_q == S_SAMPLE) begin
                trial_d = trial_q + 8'd1;
                if (ok_q) begin
                    if (timer_count_i < min_q) min_d = timer_count_i;
                    if (timer_count_i > max_q) max_d = timer_count_i;
                    sum_d  = sum_q + {8'd0, timer_count_i};
                    n_ok_d = n_ok_q + 8'd1;
                end
            end
        end
    end

    assign send_req_o    = send_req_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timer_rst_o   = t_rst_q;
    assign timer_start_o = t_start_q;
    assign timer_stop_o  = t_stop_q;
    assign min_lat_o     = min_q;
    assign max_lat_o     = max_q;
    assign sum_lat_o     = sum_q;
    assign n_ok_o        = n_ok_q;
    assign n_timeout_o   = n_to_q;

endmodule

// File: tb/tb_aurora_latency_sequencer.sv
// Directed bench for aurora_latency_sequencer with a simple cycle timer
// attached. Inputs are driven and outputs sampled on the falling edge.
module tb_aurora_latency_sequencer;
    localparam int W  = 32;
    localparam int NM = 4;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_start = 1'b0, cmd_abort = 1'b0;
    logic          send_ack = 1'b0, rx_match = 1'b0;
    logic          send_req, timer_rst, timer_start, timer_stop, busy, done;
    logic [W-1:0]  timer_count, min_lat, max_lat;
    logic [W+7:0]  sum_lat;
    logic [7:0]    n_ok, n_timeout;
    logic          running;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aurora_latency_sequencer #(.N_MEAS(NM), .TIMEOUT(TO), .WIDTH(W)) dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_start_i(cmd_start), .cmd_abort_i(cmd_abort),
        .send_req_o(send_req), .send_ack_i(send_ack), .rx_match_i(rx_match),
        .timer_rst_o(timer_rst), .timer_start_o(timer_start), .timer_stop_o(timer_stop),
        .timer_count_i(timer_count), .busy_o(busy), .done_o(done),
        .min_lat_o(min_lat), .max_lat_o(max_lat), .sum_lat_o(sum_lat),
        .n_ok_o(n_ok), .n_timeout_o(n_timeout)
    );

    // External timer: counts once per cycle after the start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_count <= '0;
            running     <= 1'b0;
        end else if (timer_rst) begin
            timer_count <= '0;
            running     <= 1'b0;
        end else if (timer_start) begin
            running <= 1'b1;
        end else if (timer_stop) begin
            running <= 1'b0;
        end else if (running) begin
            timer_count <= timer_count + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_run();
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_timer_rst", 64'(timer_rst), 64'd1);
        check("start_done_low", 64'(done), 64'd0);
        check("start_min_ones", 64'(min_lat), 64'hFFFF_FFFF);
        check("start_max_zero", 64'(max_lat), 64'd0);
        check("start_sum_zero", 64'(sum_lat), 64'd0);
        check("start_nok_zero", 64'(n_ok), 64'd0);
        step();
        check("start_send_req", 64'(send_req), 64'd1);
        check("start_rst_drop", 64'(timer_rst), 64'd0);
    endtask

    // Returns on the cycle timer_start is high.
    task automatic send_phase();
        int k = 0;
        while (!send_req && k < 10) begin
            step();
            k++;
        end
        check("send_req_seen", 64'(send_req), 64'd1);
        step();
        send_ack = 1'b1;
        step();
        send_ack = 1'b0;
        check("timer_start", 64'(timer_start), 64'd1);
        check("send_req_drop", 64'(send_req), 64'd0);
    endtask

    // rx_match d cycles after timer_start; returns on the timer_stop cycle.
    task automatic rx_phase(input int d);
        repeat (d) step();
        rx_match = 1'b1;
        step();
        rx_match = 1'b0;
        check("rx_timer_stop", 64'(timer_stop), 64'd1);
    endtask

    task automatic lost_phase();
        int k = 0;
        while (k < 200) begin
            step();
            k++;
            if (timer_stop) break;
        end
        check("timeout_stop_delay", 64'(k), 64'(TO + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        repeat (2) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_send_req", 64'(send_req), 64'd0);
        check("rst_pulses", 64'({timer_rst, timer_start, timer_stop}), 64'd0);
        check("rst_min", 64'(min_lat), 64'hFFFF_FFFF);
        check("rst_max", 64'(max_lat), 64'd0);
        check("rst_sum", 64'(sum_lat), 64'd0);
        check("rst_counts", 64'({n_ok, n_timeout}), 64'd0);
        reset = 1'b0;
        step();

        // Basic run: four trials of latency 10
        start_run();
        for (int i = 0; i < NM; i++) begin
            send_phase();
            rx_phase(10);
        end
        step();
        step();
        check("basic_not_done_r3", 64'(done), 64'd0);
        step();
        check("basic_done", 64'(done), 64'd1);
        check("basic_busy", 64'(busy), 64'd0);
        check("basic_nok", 64'(n_ok), 64'd4);
        check("basic_nto", 64'(n_timeout), 64'd0);
        check("basic_min", 64'(min_lat), 64'd10);
        check("basic_max", 64'(max_lat), 64'd10);
        check("basic_sum", 64'(sum_lat), 64'd40);
        step();
        check("done_held", 64'(done), 64'd1);

        // Restart from DONE with varying latency; stray cmd_start while busy
        start_run();
        send_phase();
        rx_phase(5);
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        check("busy_start_ignored", 64'(busy), 64'd1);
        send_phase();
        rx_phase(20);
        step();
        step();
        step();
        check("vary_partial_nok", 64'(n_ok), 64'd2);
        check("vary_partial_sum", 64'(sum_lat), 64'd25);
        send_phase();
        rx_phase(12);
        send_phase();
        rx_phase(8);
        repeat (3) step();
        check("vary_done", 64'(done), 64'd1);
        check("vary_nok", 64'(n_ok), 64'd4);
        check("vary_min", 64'(min_lat), 64'd5);
        check("vary_max", 64'(max_lat), 64'd20);
        check("vary_sum", 64'(sum_lat), 64'd45);

        // Timeout on trial 2, match exactly on the timeout cycle on trial 3
        start_run();
        send_phase();
        rx_phase(7);
        send_phase();
        lost_phase();
        check("lost_nto", 64'(n_timeout), 64'd1);
        repeat (3) step();
        check("lost_nok", 64'(n_ok), 64'd1);
        check("lost_sum", 64'(sum_lat), 64'd7);
        send_phase();
        rx_phase(TO);
        send_phase();
        rx_phase(9);
        repeat (3) step();
        check("to_done", 64'(done), 64'd1);
        check("to_nok", 64'(n_ok), 64'd3);
        check("to_nto", 64'(n_timeout), 64'd1);
        check("to_min", 64'(min_lat), 64'd7);
        check("to_max", 64'(max_lat), 64'd50);
        check("to_sum", 64'(sum_lat), 64'd66);

        // Abort together with rx_match
        start_run();
        send_phase();
        rx_phase(6);
        send_phase();
        repeat (3) step();
        rx_match  = 1'b1;
        cmd_abort = 1'b1;
        step();
        rx_match  = 1'b0;
        cmd_abort = 1'b0;
        check("abort_timer_rst", 64'(timer_rst), 64'd1);
        check("abort_timer_stop", 64'(timer_stop), 64'd1);
        check("abort_send_req", 64'(send_req), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_nok", 64'(n_ok), 64'd1);
        check("abort_min", 64'(min_lat), 64'd6);
        repeat (5) step();
        check("abort_pulses_clear", 64'({timer_rst, timer_stop, timer_start}), 64'd0);
        check("abort_stays_idle", 64'(busy), 64'd0);
        check("abort_nok_kept", 64'(n_ok), 64'd1);

        // Async reset during WAIT_RX
        start_run();
        send_phase();
        rx_phase(4);
        send_phase();
        repeat (3) step();
        check("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_send_req", 64'(send_req), 64'd0);
        check("arst_pulses", 64'({timer_rst, timer_start, timer_stop}), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_min", 64'(min_lat), 64'hFFFF_FFFF);
        check("arst_sum", 64'(sum_lat), 64'd0);
        check("arst_nok", 64'(n_ok), 64'd0);
        step();
        reset = 1'b0;
        step();
        start_run();
        for (int i = 0; i < NM; i++) begin
            send_phase();
            rx_phase(3);
        end
        repeat (3) step();
        check("post_done", 64'(done), 64'd1);
        check("post_nok", 64'(n_ok), 64'd4);
        check("post_min", 64'(min_lat), 64'd3);
        check("post_max", 64'(max_lat), 64'd3);
        check("post_sum", 64'(sum_lat), 64'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aurora_latency_sequencer.md
# aurora_latency_sequencer

Measurement controller that drives the clock-cycle timer to characterise Aurora link round-trip latency. On command it runs N_MEAS send/receive trials. For each trial it clears the timer, requests a test-pattern transmission, and starts the timer on acknowledge. It stops the timer on pattern match or timeout, then samples the count. It accumulates min/max/sum statistics for the readout register block. It sits between the link test-pattern generator/checker and one timer instance.

## Interface
- N_MEAS, 16: trials per run, legal range 1..255.
- TIMEOUT, 65535: WAIT_RX cycles before a trial is declared lost, range 1..2^24-1.
- WIDTH, 32: timer count width.
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- cmd_start  in  1  one-cycle run request.
- cmd_abort  in  1  one-cycle abort request.
- send_req  out  1  test-pattern send request, held until acknowledged.
- send_ack  in  1  generator accepted request.
- rx_match  in  1  checker saw returned pattern (pulse).
- timer_rst  out  1  synchronous clear to timer.
- timer_start  out  1  timer start pulse.
- timer_stop  out  1  timer stop pulse.
- timer_count  in  WIDTH  timer value.
- busy  out  1  run in progress.
- done  out  1  run complete, statistics valid, held until next cmd_start or reset.
- min_lat  out  WIDTH  smallest sampled latency.
- max_lat  out  WIDTH  largest sampled latency.
- sum_lat  out  WIDTH+8  sum of sampled latencies.
- n_ok  out  8  trials ended by rx_match.
- n_timeout  out  8  trials ended by timeout.

## Operation
- States: IDLE, CLEAR, SEND, WAIT_RX, SETTLE, SAMPLE, DONE.
- **IDLE / DONE:**
  - cmd_start clears min_lat to all-ones, max_lat/sum_lat/n_ok/n_timeout/trial counter to 0, and drops done.
  - Next state is CLEAR. cmd_start is ignored in all other states.
- **CLEAR:** timer_rst=1 for exactly one cycle, then SEND.
- **SEND:** send_req=1.
  - On the cycle send_ack=1 is sampled: timer_start=1 on the following cycle (one cycle), timeout counter zeroed, go WAIT_RX.
  - send_req drops the cycle after ack.
- **WAIT_RX:** timeout counter increments each cycle.
  - rx_match=1: timer_stop pulses next cycle, trial flagged ok, go SETTLE.
  - Counter reaches TIMEOUT without rx_match: timer_stop pulses, trial flagged timeout, n_timeout+1, go SETTLE.
  - rx_match on the same cycle as the timeout is treated as a match.
- **SETTLE:** 2 cycles after the timer_stop pulse, allowing the timer output to freeze; then SAMPLE.
- **SAMPLE (one cycle):**
  - Ok trial: latch timer_count, min_lat=min(min_lat,count), max_lat=max(max_lat,count), sum_lat+=count (zero-extended, no overflow possible), n_ok+1.
  - Timeout trial: statistics unchanged.
  - Trial counter +1; if equal to N_MEAS go DONE, else CLEAR.
- **DONE:** done=1, busy=0.
- **cmd_abort:**
  - Any state except IDLE/DONE: next cycle timer_stop=1 and timer_rst=1, send_req=0, go IDLE with done=0.
  - Statistics keep partial values.
  - Abort has priority over cmd_start and rx_match in the same cycle.
- rx_match and send_ack outside WAIT_RX/SEND are ignored.
- busy=1 in CLEAR through SAMPLE.

## Timing
- Reset values:
  - State IDLE.
  - All pulse outputs 0, send_req=0, busy=0, done=0.
  - min_lat all-ones; max_lat, sum_lat, n_ok, n_timeout all 0.
- All outputs are registered; no combinational input-to-output paths.
- cmd_start at cycle T: busy=1 and timer_rst=1 at T+1, send_req=1 at T+2.
- send_ack at cycle A: timer_start=1 at A+1.
- rx_match at cycle R: timer_stop=1 at R+1, SAMPLE at R+3, updated statistics visible at R+4.
- Timeout: timer_stop asserts TIMEOUT+1 cycles after timer_start.
- Per trial without ack wait: 1 CLEAR + 1 SEND + WAIT + 1 stop + 2 settle + 1 sample.
- Asynchronous reset mid-run returns immediately to reset values; no pulse is emitted.

## Test plan
- **Basic run:** N_MEAS=4, send_ack 1 cycle after send_req, rx_match 10 cycles after timer_start, with the timer model attached -> done=1, n_ok=4, n_timeout=0, min_lat=max_lat=sum_lat/4.
- **Varying latency:** rx_match delays 5, 20, 12, 8 -> min_lat/max_lat equal the timer counts for the 5 and 20 trials, and sum_lat equals the sum of all four counts.
- **Timeout:** TIMEOUT=50, no rx_match on trial 2 of 3 -> n_ok=2, n_timeout=1, timer_stop asserts 51 cycles after the trial-2 timer_start, and statistics exclude trial 2.
- **Simultaneous events:** rx_match on the timeout cycle -> counted ok. cmd_abort with rx_match in the same cycle -> IDLE, timer_rst=1, n_ok unchanged.
- **Command filtering:** cmd_start pulsed while busy -> ignored, run completes normally. cmd_start in DONE -> done drops, statistics reset, min_lat=all-ones.
- **Async reset:** reset asserted during WAIT_RX -> all outputs at reset values before the next clock edge. Next cmd_start runs cleanly.
